// File: rtl/fifo_pkg.sv
// Shared definitions for the BRAM fifo and its stream-side stages.
// Credit counters are sized to hold 0..depth inclusive.
package fifo_pkg;

  localparam int BEAT_W = 32;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
  } beat_t;

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_if.sv
// Read port of the BRAM-backed fifo: pop request, empty status, delayed read data.
// Read data appears a fixed number of cycles after each accepted pop.
interface fifo_rd_if #(
  parameter int DATA_W = 32
);
  logic              empty;
  logic              rd_en;
  logic [DATA_W-1:0] data;

  modport master (input empty, input data, output rd_en);
  modport slave  (output empty, output data, input rd_en);
endinterface

// File: rtl/stream_buf.sv
// Circular register buffer with push/pop/count and flush; head visible combinationally.
// Zero-cycle pop; push into a full buffer is illegal (caller guarantees space).
module stream_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [credit_w(DEPTH)-1:0]  count
);

  localparam int CNT_W = credit_w(DEPTH);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_pop;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop    = pop & (count_q != '0);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wrap_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = wrap_inc(rd_ptr_q);
      end
      case ({push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !do_pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the BRAM fifo against buffer credits and re-times read data into a valid/ready stream.
// Latency pop->m_valid is RD_LATENCY+1; m_ready low fills the buffer, then rd_en stops.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  fifo_rd_if.master                      rd_if,
  input  logic                           flush,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_W-1:0]              m_data,
  output logic [credit_w(BUF_DEPTH)-1:0] buf_count
);

  localparam int CNT_W = credit_w(BUF_DEPTH);

  if (BUF_DEPTH < RD_LATENCY + 2) begin : g_depth_chk
    $error("fifo_stream_reader: BUF_DEPTH must be >= RD_LATENCY+2");
  end
  if (RD_LATENCY < 0 || RD_LATENCY > 2) begin : g_lat_chk
    $error("fifo_stream_reader: RD_LATENCY must be 0..2");
  end

  logic             pop;
  logic             arrive;
  logic             wr_en;
  logic             accept;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W:0]   credit_used;

  // Credits are not netted against same-cycle accepts, so m_ready never reaches rd_en.
  assign credit_used = {1'b0, buf_count} + {1'b0, inflight};
  assign rd_if.rd_en = rst_n & ~flush & ~rd_if.empty
                     & (credit_used < (CNT_W + 1)'(BUF_DEPTH));
  assign pop         = rd_if.rd_en & ~rd_if.empty;

  if (RD_LATENCY == 0) begin : g_no_pipe
    assign arrive   = pop;
    assign inflight = '0;
  end else begin : g_pipe
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d    = pipe_q << 1;
      pipe_d[0] = pop;
      if (flush) begin
        pipe_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign arrive   = pipe_q[RD_LATENCY-1];
    assign inflight = CNT_W'($countones(pipe_q));
  end

  assign wr_en  = arrive & ~flush;
  assign accept = m_valid & m_ready;

  stream_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (wr_en),
    .push_data (rd_if.data),
    .pop       (accept),
    .out_valid (m_valid),
    .out_data  (m_data),
    .count     (buf_count)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: behavioural BRAM fifo plus a timestamped outstanding-entry scoreboard.
module tb_fifo_stream_reader;

  localparam int DW    = 32;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [CW-1:0] buf_count;

  fifo_rd_if #(.DATA_W(DW)) rd_if ();

  fifo_stream_reader #(
    .DATA_W     (DW),
    .RD_LATENCY (LAT),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_if     (rd_if),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .buf_count (buf_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned   pc;
    logic [DW-1:0] d;
  } ent_t;

  logic [DW-1:0] fifo_q[$];   // entries written, not yet popped
  ent_t          pend_q[$];   // popped entries travelling through BRAM read latency
  ent_t          out_q[$];    // popped, not yet accepted or discarded

  int unsigned cyc;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          prev_rst;

  int unsigned   obs_acc_cnt, obs_acc_first, obs_acc_last;
  int unsigned   obs_pop_cnt, obs_pop_first, obs_vld_first;
  bit            vld_seen;
  logic [DW-1:0] obs_first_d, last_data;
  logic [CW-1:0] last_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    obs_acc_cnt = 0; obs_acc_first = 0; obs_acc_last = 0;
    obs_pop_cnt = 0; obs_pop_first = 0; obs_vld_first = 0;
    vld_seen = 1'b0; obs_first_d = '0;
  endtask

  task automatic step(input bit rst, input bit fl, input bit rdy, input bit wr,
                      input logic [DW-1:0] wd);
    int            n_rdy;
    bit            ev, pop;
    logic [DW-1:0] d;
    @(negedge clk);
    rst_n   = rst;
    flush   = fl;
    m_ready = rdy;
    rd_if.empty = (fifo_q.size() == 0);
    if (LAT == 0) begin
      rd_if.data = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
    end else if (pend_q.size() != 0 && pend_q[0].pc + LAT == cyc) begin
      rd_if.data = pend_q[0].d;
      void'(pend_q.pop_front());
    end else begin
      rd_if.data = $urandom;
    end
    #1;
    n_rdy = 0;
    foreach (out_q[i]) if (out_q[i].pc + LAT + 1 <= cyc) n_rdy++;
    ev = (n_rdy != 0);
    check_eq("rd_en", rd_if.rd_en, rst && !fl && fifo_q.size() != 0 && out_q.size() < DEPTH);
    check_eq("m_valid", m_valid, ev);
    check_eq("buf_count", buf_count, n_rdy);
    if (ev) check_eq("m_data", m_data, out_q[0].d);
    else if (!prev_rst) check_eq("m_data_reset", m_data, 0);

    if (m_valid && !vld_seen) begin vld_seen = 1'b1; obs_vld_first = cyc; end
    if (m_valid && rdy) begin
      if (obs_acc_cnt == 0) begin obs_acc_first = cyc; obs_first_d = m_data; end
      obs_acc_last = cyc;
      obs_acc_cnt++;
    end
    last_cnt  = buf_count;
    last_data = m_data;

    pop = rd_if.rd_en && fifo_q.size() != 0;
    if (ev && rdy) void'(out_q.pop_front());
    if (!rst || fl) out_q.delete();
    if (pop) begin
      if (obs_pop_cnt == 0) obs_pop_first = cyc;
      obs_pop_cnt++;
      d = fifo_q.pop_front();
      if (LAT > 0) pend_q.push_back('{pc: cyc, d: d});
      if (rst && !fl) out_q.push_back('{pc: cyc, d: d});
      check_eq("credit_bound", out_q.size() <= DEPTH, 1);
    end
    if (wr) fifo_q.push_back(wd);
    prev_rst = rst;
    @(posedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || out_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, '0);
      n++;
    end
    check_eq("drain_empty", out_q.size() + fifo_q.size(), 0);
  endtask

  initial begin
    int unsigned w;
    int          written, n;
    bit          wr;
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b0;
    rd_if.empty = 1'b1; rd_if.data = '0;
    prev_rst = 1'b0;
    cyc = 0;
    clr_stats();
    @(posedge clk);
    cyc = 1;

    // Reset held while the fifo has entries: nothing may be popped.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, DW'(32'hA0 + i));
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_eq("reset_no_pop", fifo_q.size(), 3);
    drain(50);

    // Streaming 0x00..0x0F with m_ready high.
    clr_stats();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 1'b1, DW'(i));
    drain(60);
    check_eq("stream_beats", obs_acc_cnt, 16);
    check_eq("stream_span", obs_acc_last - obs_acc_first, 15);
    check_eq("stream_latency", obs_vld_first - obs_pop_first, LAT + 1);
    check_eq("stream_first", obs_first_d, 32'h00);

    // Backpressure: 10 entries, consumer stalled.
    clr_stats();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b1, DW'(32'h30 + i));
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check_eq("bp_pops", obs_pop_cnt, DEPTH);
    check_eq("bp_count", last_cnt, DEPTH);
    check_eq("bp_head", last_data, 32'h30);
    drain(80);
    check_eq("bp_total", obs_acc_cnt, 10);

    // Random writes and random m_ready, 1000 entries.
    clr_stats();
    written = 0;
    n = 0;
    while ((written < 1000 || fifo_q.size() != 0 || out_q.size() != 0) && n < 20000) begin
      wr = (written < 1000) && ($urandom_range(0, 9) < 6);
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), wr, DW'($urandom));
      if (wr) written++;
      n++;
    end
    check_eq("random_total", obs_acc_cnt, 1000);

    // Random traffic with occasional flush and mid-operation reset.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 63) != 0), 1'($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
    end
    drain(200);

    // Flush with entries buffered and one in flight; following entries still emitted.
    clr_stats();
    for (int i = 0; i < 6; i++) step(1'b1, i == 5, 1'b0, 1'b1, DW'(32'h50 + i));
    drain(40);
    check_eq("flush_after_cnt", obs_acc_cnt, 2);
    check_eq("flush_next", obs_first_d, 32'h54);

    // Write into empty fifo then immediate pop.
    clr_stats();
    w = cyc;
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h77);
    drain(20);
    check_eq("turn_pop", obs_pop_first - w, 1);
    check_eq("turn_latency", obs_vld_first - obs_pop_first, LAT + 1);
    check_eq("turn_data", obs_first_d, 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
